// File: rtl/ex_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl_pkg
// Purpose  : Shared definitions for the execute-stage hazard controller:
//            forwarding select encodings, sequencing FSM states and the
//            architectural register index width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ex_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // value being written back from MEM/WB
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result held in EX/MEM

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        DONE    = 2'd2
    } ex_state_e;

endpackage : ex_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/ex_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl_fwd_unit
// Purpose  : Combinational operand forwarding selection for the EX stage.
//            The youngest producer (EX/MEM) takes priority over MEM/WB;
//            register x0 is never forwarded.
// Ports    : id_ex_rs1_i/id_ex_rs2_i   - source registers of the EX instruction
//            ex_mem_rd_i/_regwrite_i   - producer in EX/MEM
//            mem_wb_rd_i/_regwrite_i   - producer in MEM/WB
//            forward_a_o/forward_b_o   - operand A/B select
// Revision : 1.0 - initial release
// ============================================================================
module ex_hazard_ctrl_fwd_unit
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_ex_rs1_i,
    input  logic [REG_IDX_W-1:0] id_ex_rs2_i,
    input  logic [REG_IDX_W-1:0] ex_mem_rd_i,
    input  logic                 ex_mem_regwrite_i,
    input  logic [REG_IDX_W-1:0] mem_wb_rd_i,
    input  logic                 mem_wb_regwrite_i,
    output logic [1:0]           forward_a_o,
    output logic [1:0]           forward_b_o
);

    function automatic logic [1:0] fwd_sel(input logic [REG_IDX_W-1:0] rs);
        logic [1:0] sel;
        sel = FWD_REG;
        if (ex_mem_regwrite_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == rs)) begin
            sel = FWD_MEM;
        end else if (mem_wb_regwrite_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        forward_a_o = fwd_sel(id_ex_rs1_i);
        forward_b_o = fwd_sel(id_ex_rs2_i);
    end

endmodule : ex_hazard_ctrl_fwd_unit
`default_nettype wire

// File: rtl/ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ex_hazard_ctrl
// Purpose  : Execute-stage sequencing controller for the 5-stage RV64 pipe.
//            Operand forwarding, load-use bubbles, multi-cycle EX holds,
//            taken-branch flushes and stall/flush performance counters.
// Ports    : clk, rst                       - clock, async active-high reset
//            id_*_i                         - ID-stage source registers
//            id_ex_*_i, ex_mc_start_i       - EX-stage instruction info
//            ex_mem_*_i, mem_wb_*_i         - downstream producers
//            mem_branch_taken_i             - branch resolved taken in MEM
//            pc_write_o .. ex_mem_flush_o   - pipeline enables / clears
//            forward_a_o, forward_b_o       - ALU operand selects
//            mc_busy_o                      - multi-cycle op in progress
//            stall_cycles_o, flush_count_o  - saturating perf counters
// Revision : 1.0 - initial release
// ============================================================================
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_uses_rs2_i,
    input  logic [REG_IDX_W-1:0] id_ex_rs1_i,
    input  logic [REG_IDX_W-1:0] id_ex_rs2_i,
    input  logic [REG_IDX_W-1:0] id_ex_rd_i,
    input  logic                 id_ex_memread_i,
    input  logic                 ex_mc_start_i,
    input  logic [REG_IDX_W-1:0] ex_mem_rd_i,
    input  logic                 ex_mem_regwrite_i,
    input  logic [REG_IDX_W-1:0] mem_wb_rd_i,
    input  logic                 mem_wb_regwrite_i,
    input  logic                 mem_branch_taken_i,
    output logic                 pc_write_o,
    output logic                 pc_sel_branch_o,
    output logic                 if_id_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_write_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_flush_o,
    output logic [1:0]           forward_a_o,
    output logic [1:0]           forward_b_o,
    output logic                 mc_busy_o,
    output logic [CNT_W-1:0]     stall_cycles_o,
    output logic [CNT_W-1:0]     flush_count_o
);

    // Wide enough for the largest legal latency (16)
    localparam int                  MC_CNT_W = 5;
    localparam logic [MC_CNT_W-1:0] MC_LOAD  = MC_CNT_W'(MC_LATENCY - 1);
    localparam logic [MC_CNT_W-1:0] MC_ONE   = MC_CNT_W'(1);

    ex_state_e           state_q, state_d;
    logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0]    stall_cycles_q, flush_count_q;
    logic                load_use;

    ex_hazard_ctrl_fwd_unit u_fwd_unit (
        .id_ex_rs1_i       (id_ex_rs1_i),
        .id_ex_rs2_i       (id_ex_rs2_i),
        .ex_mem_rd_i       (ex_mem_rd_i),
        .ex_mem_regwrite_i (ex_mem_regwrite_i),
        .mem_wb_rd_i       (mem_wb_rd_i),
        .mem_wb_regwrite_i (mem_wb_regwrite_i),
        .forward_a_o       (forward_a_o),
        .forward_b_o       (forward_b_o)
    );

    assign load_use = id_ex_memread_i && (id_ex_rd_i != '0) &&
                      ((id_ex_rd_i == id_rs1_i) ||
                       (id_uses_rs2_i && (id_ex_rd_i == id_rs2_i)));

    always_comb begin
        state_d         = state_q;
        mc_cnt_d        = mc_cnt_q;
        pc_write_o      = 1'b1;
        pc_sel_branch_o = 1'b0;
        if_id_write_o   = 1'b1;
        if_id_flush_o   = 1'b0;
        id_ex_write_o   = 1'b1;
        id_ex_flush_o   = 1'b0;
        ex_mem_flush_o  = 1'b0;

        if (mem_branch_taken_i) begin
            // Taken branch overrides everything and aborts any multi-cycle op
            pc_sel_branch_o = 1'b1;
            if_id_flush_o   = 1'b1;
            id_ex_flush_o   = 1'b1;
            ex_mem_flush_o  = 1'b1;
            state_d         = RUN;
            mc_cnt_d        = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_mc_start_i) begin
                        pc_write_o     = 1'b0;
                        if_id_write_o  = 1'b0;
                        id_ex_write_o  = 1'b0;
                        ex_mem_flush_o = 1'b1;
                        state_d        = MC_BUSY;
                        mc_cnt_d       = MC_LOAD;
                    end else if (load_use) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_flush_o = 1'b1;
                    end
                end
                MC_BUSY: begin
                    mc_cnt_d = mc_cnt_q - MC_ONE;
                    if (mc_cnt_q > MC_ONE) begin
                        pc_write_o     = 1'b0;
                        if_id_write_o  = 1'b0;
                        id_ex_write_o  = 1'b0;
                        ex_mem_flush_o = 1'b1;
                    end else begin
                        // Last occupancy cycle: enables open, result moves on
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // ex_mc_start is deliberately ignored so the op is not restarted
                    state_d = RUN;
                end
                default: begin
                    state_d  = RUN;
                    mc_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            mc_cnt_q       <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            if (!pc_write_o && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
            if (mem_branch_taken_i && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign mc_busy_o      = (state_q == MC_BUSY);
    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;

endmodule : ex_hazard_ctrl
`default_nettype wire

// File: tb/tb_ex_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_hazard_ctrl
// Purpose  : Directed self-checking bench for ex_hazard_ctrl (MC_LATENCY=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic        id_uses_rs2, id_ex_memread, ex_mc_start, ex_mem_regwrite;
    logic        mem_wb_regwrite, mem_branch_taken;
    logic        pc_write, pc_sel_branch, if_id_write, if_id_flush;
    logic        id_ex_write, id_ex_flush, ex_mem_flush, mc_busy;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] stall_cycles, flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    ex_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(32)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .id_rs1_i           (id_rs1),
        .id_rs2_i           (id_rs2),
        .id_uses_rs2_i      (id_uses_rs2),
        .id_ex_rs1_i        (id_ex_rs1),
        .id_ex_rs2_i        (id_ex_rs2),
        .id_ex_rd_i         (id_ex_rd),
        .id_ex_memread_i    (id_ex_memread),
        .ex_mc_start_i      (ex_mc_start),
        .ex_mem_rd_i        (ex_mem_rd),
        .ex_mem_regwrite_i  (ex_mem_regwrite),
        .mem_wb_rd_i        (mem_wb_rd),
        .mem_wb_regwrite_i  (mem_wb_regwrite),
        .mem_branch_taken_i (mem_branch_taken),
        .pc_write_o         (pc_write),
        .pc_sel_branch_o    (pc_sel_branch),
        .if_id_write_o      (if_id_write),
        .if_id_flush_o      (if_id_flush),
        .id_ex_write_o      (id_ex_write),
        .id_ex_flush_o      (id_ex_flush),
        .ex_mem_flush_o     (ex_mem_flush),
        .forward_a_o        (forward_a),
        .forward_b_o        (forward_b),
        .mc_busy_o          (mc_busy),
        .stall_cycles_o     (stall_cycles),
        .flush_count_o      (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample/drive 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
        id_ex_rs1 = 0; id_ex_rs2 = 0; id_ex_rd = 0; id_ex_memread = 0;
        ex_mc_start = 0; ex_mem_rd = 0; ex_mem_regwrite = 0;
        mem_wb_rd = 0; mem_wb_regwrite = 0; mem_branch_taken = 0;
    endtask

    task automatic set_load_use();
        id_ex_memread = 1; id_ex_rd = 7; id_rs1 = 3; id_rs2 = 7; id_uses_rs2 = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #2;
        check("rst_mc_busy", mc_busy, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_flush", flush_count, 0);
        check("rst_pc_write", pc_write, 1);
        check("rst_id_ex_write", id_ex_write, 1);
        check("rst_ex_mem_flush", ex_mem_flush, 0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- forwarding ----------------
        ex_mem_rd = 5; ex_mem_regwrite = 1; mem_wb_rd = 5; mem_wb_regwrite = 1;
        id_ex_rs1 = 5; id_ex_rs2 = 5;
        #1;
        check("fwd_a_mem", forward_a, 2'b10);
        check("fwd_b_mem", forward_b, 2'b10);
        ex_mem_rd = 0;
        #1;
        check("fwd_a_wb", forward_a, 2'b01);
        id_ex_rs1 = 0; mem_wb_rd = 0;
        #1;
        check("fwd_a_x0", forward_a, 2'b00);
        ex_mem_rd = 9; ex_mem_regwrite = 0; mem_wb_rd = 9; id_ex_rs2 = 9;
        #1;
        check("fwd_b_wb_no_regwrite_mem", forward_b, 2'b01);
        mem_wb_regwrite = 0;
        #1;
        check("fwd_b_none", forward_b, 2'b00);
        clear_inputs();

        // ---------------- load-use ----------------
        set_load_use();
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_if_id_write", if_id_write, 0);
        check("lu_id_ex_flush", id_ex_flush, 1);
        check("lu_id_ex_write", id_ex_write, 1);
        tick();
        check("lu_stall_cnt", stall_cycles, 1);
        id_uses_rs2 = 0;
        #1;
        check("lu_rs2_unused", pc_write, 1);
        clear_inputs();

        // ---------------- multi-cycle (latency 4) with load-use masked ----------------
        ex_mc_start = 1;
        set_load_use();
        #1;
        check("mc0_pc_write", pc_write, 0);
        check("mc0_ex_mem_flush", ex_mem_flush, 1);
        check("mc0_id_ex_flush", id_ex_flush, 0);
        check("mc0_busy", mc_busy, 0);
        tick();
        check("mc1_busy", mc_busy, 1);
        check("mc1_id_ex_write", id_ex_write, 0);
        tick();
        check("mc2_busy", mc_busy, 1);
        check("mc2_pc_write", pc_write, 0);
        tick();
        check("mc3_busy", mc_busy, 1);
        check("mc3_pc_write", pc_write, 1);
        check("mc3_if_id_write", if_id_write, 1);
        check("mc3_ex_mem_flush", ex_mem_flush, 0);
        check("mc3_id_ex_flush", id_ex_flush, 0);
        tick();
        check("mc_done_busy", mc_busy, 0);
        check("mc_done_pc_write", pc_write, 1);
        check("mc_done_id_ex_write", id_ex_write, 1);
        clear_inputs();
        tick();
        check("mc_stall_cnt", stall_cycles, 4);
        check("mc_back_run", mc_busy, 0);

        // ---------------- branch during MC_BUSY ----------------
        ex_mc_start = 1;
        tick();
        check("br_mc_busy", mc_busy, 1);
        mem_branch_taken = 1; ex_mc_start = 0;
        #1;
        check("br_pc_sel", pc_sel_branch, 1);
        check("br_pc_write", pc_write, 1);
        check("br_if_id_flush", if_id_flush, 1);
        check("br_id_ex_flush", id_ex_flush, 1);
        check("br_ex_mem_flush", ex_mem_flush, 1);
        tick();
        mem_branch_taken = 0;
        #1;
        check("br_after_busy", mc_busy, 0);
        check("br_flush_cnt", flush_count, 1);
        check("br_after_pc_write", pc_write, 1);
        check("br_stall_cnt", stall_cycles, 5);

        // ---------------- branch + load-use ----------------
        set_load_use();
        mem_branch_taken = 1;
        #1;
        check("brlu_pc_write", pc_write, 1);
        check("brlu_pc_sel", pc_sel_branch, 1);
        check("brlu_id_ex_flush", id_ex_flush, 1);
        tick();
        clear_inputs();
        #1;
        check("brlu_stall_cnt", stall_cycles, 5);
        check("brlu_flush_cnt", flush_count, 2);

        // ---------------- async reset mid-MC_BUSY ----------------
        ex_mc_start = 1;
        tick();
        tick();
        check("ar_pre_busy", mc_busy, 1);
        #2;
        rst = 1'b1; ex_mc_start = 0;
        #1;
        check("ar_busy", mc_busy, 0);
        check("ar_stall", stall_cycles, 0);
        check("ar_flush", flush_count, 0);
        check("ar_pc_write", pc_write, 1);
        check("ar_if_id_write", if_id_write, 1);
        check("ar_ex_mem_flush", ex_mem_flush, 0);
        tick();
        rst = 1'b0;
        tick();
        check("ar_post_busy", mc_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ex_hazard_ctrl
`default_nettype wire
